harness_run_ctrl: RTL and testbench
===================================

// Module: harness_run_ctrl
// PURPOSE
//  Synthesizable run controller for the simulation top. It replaces the free-running reset/timeout
//  logic with a sequenced state machine, which lets the DUT harness run on emulation and multi-core
//  simulation backends. It sequences DUT reset, counts run cycles, gates printf output and watches
//  the harness success signal. It reports pass, timeout or abort to the host through sticky status.
// PARAMETERS
//  RESET_DELAY   4   cycles dut_reset is held high after a run starts (>=1)
//  CNT_W         64  width of max_cycles and cycle_count
//  DRAIN_CYCLES  16  cycles the DUT keeps running after success so printf/log traffic can flush (>=1)
//  HB_LOG2       20  heartbeat period is 2**HB_LOG2 run cycles
// PORTS
//  clk          in   1      clock
//  reset_n      in   1      synchronous active-low reset
//  start        in   1      level; starts or restarts a run when state is IDLE or DONE
//  max_cycles   in   CNT_W  timeout limit, sampled on start; 0 = no timeout
//  verbose      in   1      printf enable, sampled on start
//  abort        in   1      host abort request
//  dut_success  in   1      harness io_success
//  dut_reset    out  1      active-high reset to the DUT harness
//  printf_cond  out  1      verbose_q && (state==RUN || state==DRAIN)
//  running      out  1      state==RUN || state==DRAIN
//  done         out  1      state==DONE
//  pass         out  1      sticky: run ended via dut_success
//  timed_out    out  1      sticky: run ended via max_cycles
//  aborted      out  1      sticky: run ended via abort
//  cycle_count  out  CNT_W  RUN-state cycle count; frozen outside RUN
//  heartbeat    out  1      1-cycle pulse every 2**HB_LOG2 RUN cycles
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): state=IDLE. dut_reset=1. cycle_count=0. All other outputs 0. Latched max/verbose=0.
//  - States: IDLE, RST, RUN, DRAIN, DONE. All outputs are registered; each output changes one edge after its cause.
//  - IDLE/DONE + start=1: latch max_q=max_cycles and verbose_q=verbose.
//    Clear pass/timed_out/aborted and cycle_count. Go to RST. A reset counter loads RESET_DELAY-1.
//  - RST: dut_reset=1 for exactly RESET_DELAY cycles, then RUN. abort in RST -> DONE, aborted=1.
//  - RUN: dut_reset=0. cycle_count=0 in the first RUN cycle and increments by 1 each RUN cycle.
//    The counter wraps modulo 2**CNT_W only if max_q==0. Per-cycle priority:
//    abort > dut_success > timeout.
//    * abort: go to DONE, aborted=1, dut_reset=1.
//    * dut_success: go to DRAIN, pass=1, cycle_count freezes at its current value.
//    * max_q!=0 && cycle_count==max_q: go to DONE, timed_out=1, dut_reset=1.
//  - DRAIN: dut_reset=0 for DRAIN_CYCLES cycles, then DONE with dut_reset=1. abort during DRAIN
//    goes to DONE immediately and sets aborted. pass stays 1, so both flags may be set.
//    dut_success is ignored in DRAIN.
//  - DONE: status flags and cycle_count hold. dut_reset=1. start restarts the run (see above).
//  - start is ignored in RST/RUN/DRAIN. Changes to max_cycles or verbose after start are ignored.
//  - heartbeat=1 for one cycle when state==RUN && cycle_count[HB_LOG2-1:0]=='1.
//  - reset_n low at any point, including mid-run, aborts immediately to the reset state above.
//    No status is kept.
//  - Exactly one of pass/timed_out/aborted is set on entry to DONE. The only exception is pass+aborted
//    when abort arrives during DRAIN.
// TESTING
//  1. RESET_DELAY=4, start=1 one cycle, max=1000, success at cycle_count=37 -> dut_reset high exactly
//     4 cycles. DRAIN for 16 cycles. done=1, pass=1, cycle_count=37.
//  2. max=10, no success -> RUN lasts 11 cycles (cycle_count 0..10). timed_out=1, dut_reset=1 on the
//     next edge. cycle_count=10.
//  3. max=10, dut_success and abort both asserted at cycle_count=10 -> aborted=1, pass=0, timed_out=0.
//  4. verbose=1 at start, then verbose=0 mid-run -> printf_cond=0 in RST, 1 in RUN/DRAIN, 0 in DONE.
//  5. reset_n=0 mid-RUN at cycle_count=5 -> next cycle IDLE, dut_reset=1, all flags 0, cycle_count=0.
//     Restart proceeds normally.
//  6. HB_LOG2=3, max=0, run 20 cycles -> heartbeat pulses at cycle_count 7 and 15 only.
//     start asserted during RUN has no effect.

Source files
------------

// File: rtl/harness_run_ctrl_if.sv
// Control/status bundle between the host-side run sequencer and harness_run_ctrl.
// The master drives the run requests and the DUT success; the slave reports status.
interface harness_run_ctrl_if #(
  parameter int unsigned CNT_W = 64
);
  logic             start;
  logic [CNT_W-1:0] max_cycles;
  logic             verbose;
  logic             abort;
  logic             dut_success;
  logic             dut_reset;
  logic             printf_cond;
  logic             running;
  logic             done;
  logic             pass;
  logic             timed_out;
  logic             aborted;
  logic [CNT_W-1:0] cycle_count;
  logic             heartbeat;

  modport master (
    output start, max_cycles, verbose, abort, dut_success,
    input  dut_reset, printf_cond, running, done, pass, timed_out, aborted, cycle_count,
           heartbeat
  );

  modport slave (
    input  start, max_cycles, verbose, abort, dut_success,
    output dut_reset, printf_cond, running, done, pass, timed_out, aborted, cycle_count,
           heartbeat
  );
endinterface

// File: rtl/harness_run_ctrl.sv
// Run controller for the simulation top: sequences DUT reset, counts run cycles, gates printf
// and reports pass / timeout / abort through sticky status flags.
module harness_run_ctrl #(
  parameter int unsigned RESET_DELAY  = 4,
  parameter int unsigned CNT_W        = 64,
  parameter int unsigned DRAIN_CYCLES = 16,
  parameter int unsigned HB_LOG2      = 20
) (
  input logic               clk,
  input logic               reset_n,
  harness_run_ctrl_if.slave ctrl
);

  localparam int unsigned MaxDly = (RESET_DELAY > DRAIN_CYCLES) ? RESET_DELAY : DRAIN_CYCLES;
  localparam int unsigned DlyW   = $clog2(MaxDly + 1);

  typedef enum logic [2:0] {StIdle, StRst, StRun, StDrain, StDone} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] max_q;
  logic [CNT_W-1:0] cnt_q;
  logic             verbose_q;
  logic [DlyW-1:0]  dly_q;
  logic             dut_reset_q;
  logic             printf_q;
  logic             running_q;
  logic             done_q;
  logic             pass_q;
  logic             timed_out_q;
  logic             aborted_q;
  logic             hb_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      max_q       <= '0;
      cnt_q       <= '0;
      verbose_q   <= 1'b0;
      dly_q       <= '0;
      dut_reset_q <= 1'b1;
      printf_q    <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timed_out_q <= 1'b0;
      aborted_q   <= 1'b0;
      hb_q        <= 1'b0;
    end else begin
      hb_q <= (state_q == StRun) && (&cnt_q[HB_LOG2-1:0]);
      unique case (state_q)
        StIdle, StDone: begin
          if (ctrl.start) begin
            max_q       <= ctrl.max_cycles;
            verbose_q   <= ctrl.verbose;
            cnt_q       <= '0;
            pass_q      <= 1'b0;
            timed_out_q <= 1'b0;
            aborted_q   <= 1'b0;
            done_q      <= 1'b0;
            dly_q       <= DlyW'(RESET_DELAY - 1);
            state_q     <= StRst;
          end
        end
        StRst: begin
          if (ctrl.abort) begin
            aborted_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= StDone;
          end else if (dly_q == '0) begin
            dut_reset_q <= 1'b0;
            running_q   <= 1'b1;
            printf_q    <= verbose_q;
            state_q     <= StRun;
          end else begin
            dly_q <= dly_q - 1'b1;
          end
        end
        StRun: begin
          // abort > dut_success > timeout; cnt_q freezes on any exit
          if (ctrl.abort || (!ctrl.dut_success && max_q != '0 && cnt_q == max_q)) begin
            aborted_q   <= ctrl.abort;
            timed_out_q <= !ctrl.abort;
            dut_reset_q <= 1'b1;
            running_q   <= 1'b0;
            printf_q    <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= StDone;
          end else if (ctrl.dut_success) begin
            pass_q  <= 1'b1;
            dly_q   <= DlyW'(DRAIN_CYCLES - 1);
            state_q <= StDrain;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDrain: begin
          if (ctrl.abort || dly_q == '0) begin
            aborted_q   <= ctrl.abort;
            dut_reset_q <= 1'b1;
            running_q   <= 1'b0;
            printf_q    <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= StDone;
          end else begin
            dly_q <= dly_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ctrl.dut_reset   = dut_reset_q;
  assign ctrl.printf_cond = printf_q;
  assign ctrl.running     = running_q;
  assign ctrl.done        = done_q;
  assign ctrl.pass        = pass_q;
  assign ctrl.timed_out   = timed_out_q;
  assign ctrl.aborted     = aborted_q;
  assign ctrl.cycle_count = cnt_q;
  assign ctrl.heartbeat   = hb_q;

endmodule

// File: tb/tb_harness_run_ctrl.sv
// Self-checking bench for harness_run_ctrl: directed and random runs checked cycle by cycle
// against a run-level timeline computed from start time, reset delay, end event and drain length.
module tb_harness_run_ctrl;
  localparam int RD  = 4;
  localparam int CW  = 16;
  localparam int DR  = 16;
  localparam int HB  = 3;
  localparam int HBP = 1 << HB;

  logic clk;
  logic reset_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  harness_run_ctrl_if #(.CNT_W(CW)) bus ();

  harness_run_ctrl #(
    .RESET_DELAY (RD),
    .CNT_W       (CW),
    .DRAIN_CYCLES(DR),
    .HB_LOG2     (HB)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .ctrl   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " dut_reset"}, 64'(bus.dut_reset), 64'd1);
    chk({tag, " running"}, 64'(bus.running), 64'd0);
    chk({tag, " done"}, 64'(bus.done), 64'd0);
    chk({tag, " printf_cond"}, 64'(bus.printf_cond), 64'd0);
    chk({tag, " pass"}, 64'(bus.pass), 64'd0);
    chk({tag, " timed_out"}, 64'(bus.timed_out), 64'd0);
    chk({tag, " aborted"}, 64'(bus.aborted), 64'd0);
    chk({tag, " cycle_count"}, 64'(bus.cycle_count), 64'd0);
    chk({tag, " heartbeat"}, 64'(bus.heartbeat), 64'd0);
  endtask

  // ap: 0 none, 1 abort in reset phase, 2 abort at run count a_at, 3 abort at drain index a_at.
  // s: cycle_count at which dut_success is raised, or -1.
  task automatic run_scn(input int mx, input bit vb, input int s, input int ap, input int a_at);
    int kind;  // 0 timeout, 1 success, 2 abort in run, 3 abort in reset phase
    int e, abort_t, done_t, succ_t;
    bit drain_ab;
    e = 0; abort_t = -1; drain_ab = 1'b0; kind = 0; done_t = 0;
    if (ap == 1) begin
      kind = 3; abort_t = a_at; done_t = a_at + 1;
    end else begin
      e = 1 << 30;
      if (mx != 0) e = mx;
      if (s >= 0 && s <= e) e = s;
      if (ap == 2 && a_at <= e) e = a_at;
      if (ap == 2 && a_at == e) kind = 2;
      else if (s >= 0 && s == e) kind = 1;
      else kind = 0;
      if (kind == 2) begin
        abort_t = RD + e; done_t = RD + e + 1;
      end else if (kind == 1) begin
        if (ap == 3) begin
          drain_ab = 1'b1; abort_t = RD + e + 1 + a_at; done_t = abort_t + 1;
        end else begin
          done_t = RD + e + 1 + DR;
        end
      end else begin
        done_t = RD + e + 1;
      end
    end
    succ_t = (s >= 0) ? RD + s : -1;

    bus.max_cycles  = CW'(mx);
    bus.verbose     = vb;
    bus.start       = 1'b1;
    bus.abort       = 1'b0;
    bus.dut_success = 1'b0;
    for (int t = 0; t <= done_t + 2; t++) begin
      bit run_e;
      int cnt_e, tp;
      bit hb_e;
      @(posedge clk); #1;
      run_e = (t >= RD && t < done_t);
      cnt_e = (kind == 3 || t < RD) ? 0 : ((t <= RD + e) ? t - RD : e);
      tp    = t - 1 - RD;
      hb_e  = (kind != 3 && tp >= 0 && tp <= e && (tp % HBP) == HBP - 1);
      chk("dut_reset", 64'(bus.dut_reset), 64'(!run_e));
      chk("running", 64'(bus.running), 64'(run_e));
      chk("done", 64'(bus.done), 64'(t >= done_t));
      chk("printf_cond", 64'(bus.printf_cond), 64'(vb && run_e));
      chk("pass", 64'(bus.pass), 64'(kind == 1 && t >= RD + e + 1));
      chk("timed_out", 64'(bus.timed_out), 64'(kind == 0 && t >= done_t));
      chk("aborted", 64'(bus.aborted), 64'((kind >= 2 || drain_ab) && t >= done_t));
      chk("cycle_count", 64'(bus.cycle_count), 64'(cnt_e));
      chk("heartbeat", 64'(bus.heartbeat), 64'(hb_e));
      // inputs seen by the next edge
      bus.abort       = (t == abort_t);
      bus.dut_success = (t == succ_t) ||
                        (kind == 1 && t > RD + e && t < done_t && $urandom_range(0, 3) == 0);
      bus.start       = (t < done_t) && ($urandom_range(0, 7) == 0);
      bus.verbose     = 1'($urandom);
      bus.max_cycles  = CW'($urandom_range(1, 8));
    end
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.dut_success = 1'b0;
  endtask

  initial begin
    int mx, s, ap, a_at;
    bit vb;
    reset_n         = 1'b0;
    bus.start       = 1'b0;
    bus.max_cycles  = '0;
    bus.verbose     = 1'b0;
    bus.abort       = 1'b0;
    bus.dut_success = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("por");
    reset_n = 1'b1;

    run_scn(1000, 1'b0, 37, 0, 0);  // success then drain
    run_scn(10, 1'b1, -1, 0, 0);    // timeout at count 10
    run_scn(10, 1'b0, 10, 2, 10);   // abort beats success and timeout
    run_scn(40, 1'b1, 25, 0, 0);    // verbose latched, toggled mid-run
    run_scn(0, 1'b0, 20, 0, 0);     // heartbeat at 7 and 15, no timeout
    run_scn(50, 1'b0, -1, 1, 2);    // abort during reset phase
    run_scn(50, 1'b1, 5, 3, 7);     // abort during drain keeps pass
    run_scn(1, 1'b1, 1, 0, 0);      // success wins over timeout

    // reset mid-run at cycle_count 5
    bus.max_cycles = '0;
    bus.verbose    = 1'b1;
    bus.start      = 1'b1;
    for (int t = 0; t <= RD + 5; t++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    chk("midrun cycle_count", 64'(bus.cycle_count), 64'd5);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk_reset_state("midrun reset");
    run_scn(30, 1'b1, 12, 0, 0);

    for (int i = 0; i < 20; i++) begin
      mx = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 60));
      vb = 1'($urandom);
      s  = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 70)) : -1;
      if (mx == 0 && s < 0) s = int'($urandom_range(0, 40));
      ap = int'($urandom_range(0, 5));
      ap = (ap <= 2) ? 0 : ap - 2;
      a_at = (ap == 1) ? int'($urandom_range(0, RD - 1)) :
             (ap == 2) ? int'($urandom_range(0, 70)) : int'($urandom_range(0, DR - 1));
      run_scn(mx, vb, s, ap, a_at);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
